// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU constants and writeback request type; no logic.
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xdata_t;

    typedef struct packed {
        logic      vld;
        reg_addr_t rd;
        xdata_t    dat;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_tag.sv
// In-order tag FIFO, zero-latency head read. The caller pushes only when it is
// not full and pops only when it is not empty; no backpressure is applied here.
module tag_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with load scoreboard: memory responses win the
// port, 1-cycle registered write; ALU and load issue are held off by busy/full.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    input  logic [REG_ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]         alu_data,
    output logic                    alu_ready,
    input  logic                    ld_issue_valid,
    input  logic [REG_ADDR_W-1:0]   ld_issue_rd,
    output logic                    ld_issue_ready,
    input  logic                    mem_rsp_valid,
    input  logic [XLEN-1:0]         mem_rsp_data,
    input  logic [REG_ADDR_W-1:0]   rs1Id,
    input  logic [REG_ADDR_W-1:0]   rs2Id,
    output logic                    hazard,
    output logic                    wr_en,
    output logic [REG_ADDR_W-1:0]   rdId,
    output logic [XLEN-1:0]         rd_data,
    output logic [$clog2(LD_DEPTH):0] pending_cnt,
    output logic                    rsp_err
);

    localparam int CNT_W = $clog2(LD_DEPTH) + 1;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wr_en_q;
    reg_addr_t           rd_id_q;
    xdata_t              rd_data_q;
    logic                rsp_err_q;

    reg_addr_t           head;
    logic [CNT_W-1:0]    cnt;
    logic                rsp_pop, ld_push, alu_grant;
    wb_req_t             grant;

    tag_fifo #(
        .WIDTH (REG_ADDR_W),
        .DEPTH (LD_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (ld_push),
        .push_dat_i (ld_issue_rd),
        .pop_i      (rsp_pop),
        .head_o     (head),
        .count_o    (cnt)
    );

    // A response with nothing outstanding is dropped and only flags rsp_err.
    assign rsp_pop        = mem_rsp_valid && (cnt != '0);
    assign ld_issue_ready = (cnt < CNT_W'(LD_DEPTH)) && !busy_q[ld_issue_rd];
    assign ld_push        = ld_issue_valid && ld_issue_ready;
    assign alu_ready      = !rsp_pop && !busy_q[alu_rd];
    assign alu_grant      = alu_valid && alu_ready;

    always_comb begin
        busy_d = busy_q;
        if (rsp_pop) begin
            busy_d[head] = 1'b0;
        end
        if (ld_push && (ld_issue_rd != '0)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        grant = '0;
        if (rsp_pop) begin
            grant.vld = 1'b1;
            grant.rd  = head;
            grant.dat = mem_rsp_data;
        end else if (alu_grant) begin
            grant.vld = 1'b1;
            grant.rd  = alu_rd;
            grant.dat = alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            rd_id_q   <= '0;
            rd_data_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            // A grant to x0 is consumed but never reaches the bank.
            wr_en_q <= grant.vld && (grant.rd != '0);
            if (grant.vld) begin
                rd_id_q   <= grant.rd;
                rd_data_q <= grant.dat;
            end
            if (mem_rsp_valid && (cnt == '0)) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign hazard = busy_q[rs1Id] || busy_q[rs2Id] ||
                    (wr_en_q && (rd_id_q != '0) && ((rd_id_q == rs1Id) || (rd_id_q == rs2Id)));

    assign wr_en       = wr_en_q;
    assign rdId        = rd_id_q;
    assign rd_data     = rd_data_q;
    assign pending_cnt = cnt;
    assign rsp_err     = rsp_err_q;

endmodule
